// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with a start/busy/done handshake.
// Operations: ADD, INC, AND, OR, XOR, NOT, ROL (one bit per clock) and CLR.
// Defining SEQ_ALU_SUB_EN turns func 3'b111 from CLR into SUB (b - c).
// Result and flags are registered and only change on completion or reset.
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             sign
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    localparam logic [2:0] FuncAdd = 3'b000;
    localparam logic [2:0] FuncInc = 3'b001;
    localparam logic [2:0] FuncAnd = 3'b010;
    localparam logic [2:0] FuncOr  = 3'b011;
    localparam logic [2:0] FuncXor = 3'b100;
    localparam logic [2:0] FuncNot = 3'b101;
    localparam logic [2:0] FuncRol = 3'b110;
    localparam logic [2:0] FuncClr = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StRot,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     sh_q, sh_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 carry_q, carry_d;
    logic                 zero_q, zero_d;
    logic                 sign_q, sign_d;

    logic [WIDTH:0]       add_w;
    logic [WIDTH:0]       inc_w;
    logic [WIDTH-1:0]     op_res;
    logic                 op_carry;
    logic [SHAMT_W-1:0]   rol_n;
    logic [WIDTH-1:0]     rot_next;
    logic                 wr_en;
    logic [WIDTH-1:0]     wr_val;
    logic                 wr_carry;

    assign add_w    = {1'b0, b} + {1'b0, c};
    assign inc_w    = {1'b0, b} + (WIDTH+1)'(1);
    assign rol_n    = c[SHAMT_W-1:0];
    assign rot_next = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};

`ifdef SEQ_ALU_SUB_EN
    logic [WIDTH:0] sub_w;
    // b + ~c + 1; bit WIDTH is the no-borrow flag
    assign sub_w = {1'b0, b} + {1'b0, ~c} + (WIDTH+1)'(1);
`endif

    // Single-cycle operation results from the live inputs (used only on accept)
    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        unique case (func)
            FuncAdd: begin
                op_res   = add_w[WIDTH-1:0];
                op_carry = add_w[WIDTH];
            end
            FuncInc: begin
                op_res   = inc_w[WIDTH-1:0];
                op_carry = inc_w[WIDTH];
            end
            FuncAnd: op_res = b & c;
            FuncOr:  op_res = b | c;
            FuncXor: op_res = b ^ c;
            FuncNot: op_res = ~b;
            FuncRol: op_res = b;
            FuncClr: begin
`ifdef SEQ_ALU_SUB_EN
                op_res   = sub_w[WIDTH-1:0];
                op_carry = sub_w[WIDTH];
`else
                op_res   = '0;
`endif
            end
            default: op_res = '0;
        endcase
    end

    // FSM next state, rotate datapath and completion write of result/flags
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        sign_d   = sign_q;
        wr_en    = 1'b0;
        wr_val   = '0;
        wr_carry = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (func == FuncRol) begin
                        if (rol_n == '0) begin
                            wr_en   = 1'b1;
                            wr_val  = b;
                            state_d = StDone;
                        end else begin
                            sh_d    = b;
                            cnt_d   = rol_n;
                            state_d = StRot;
                        end
                    end else begin
                        wr_en    = 1'b1;
                        wr_val   = op_res;
                        wr_carry = op_carry;
                        state_d  = StDone;
                    end
                end
            end
            StRot: begin
                sh_d  = rot_next;
                cnt_d = cnt_q - SHAMT_W'(1);
                // Last step: carry is the MSB rotated out on this edge
                if (cnt_q == SHAMT_W'(1)) begin
                    wr_en    = 1'b1;
                    wr_val   = rot_next;
                    wr_carry = sh_q[WIDTH-1];
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (wr_en) begin
            result_d = wr_val;
            carry_d  = wr_carry;
            zero_d   = (wr_val == '0);
            sign_d   = wr_val[WIDTH-1];
        end
    end

    // State and output registers; reset abandons any rotate in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            sh_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign sign   = sign_q;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: directed vector table, hand sequences and random ops vs model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  func = 3'b000;
    logic [7:0]  b = 8'h00;
    logic [7:0]  c = 8'h00;
    logic        busy, done, carry, zero, sign;
    logic [7:0]  result;

    logic        start16 = 1'b0;
    logic [2:0]  func16 = 3'b000;
    logic [15:0] b16 = 16'h0;
    logic [15:0] c16 = 16'h0;
    logic        busy16, done16, carry16, zero16, sign16;
    logic [15:0] result16;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .func(func), .b(b), .c(c),
        .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero), .sign(sign)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .func(func16), .b(b16), .c(c16),
        .busy(busy16), .done(done16), .result(result16), .carry(carry16), .zero(zero16),
        .sign(sign16)
    );

    typedef struct {
        logic [2:0] f;
        logic [7:0] bv;
        logic [7:0] cv;
        logic [7:0] r;
        logic       cy;
        int         lat;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: result, carry and latency from the arithmetic definitions
    function automatic void model(input logic [2:0] f, input logic [7:0] bv, input logic [7:0] cv,
                                  output logic [7:0] r, output logic cy, output int lat);
        int unsigned bi = bv;
        int unsigned ci = cv;
        int unsigned s;
        int unsigned n;
        r = 8'h00; cy = 1'b0; lat = 0;
        case (f)
            3'd0: begin s = bi + ci; r = 8'(s % 256); cy = (s >= 256); end
            3'd1: begin s = bi + 1;  r = 8'(s % 256); cy = (s >= 256); end
            3'd2: r = bv & cv;
            3'd3: r = bv | cv;
            3'd4: r = bv ^ cv;
            3'd5: r = ~bv;
            3'd6: begin
                n = ci % 8;
                lat = int'(n);
                if (n == 0) r = bv;
                else begin
                    r  = 8'(((bi << n) | (bi >> (8 - n))) % 256);
                    cy = ((bi >> (8 - n)) & 1) != 0;
                end
            end
            default: begin
`ifdef SEQ_ALU_SUB_EN
                r  = 8'((bi + 256 - ci) % 256);
                cy = (bi >= ci);
`else
                r  = 8'h00;
`endif
            end
        endcase
    endfunction

    // Issue one op, scramble inputs after accept, and check timing plus outputs
    task automatic apply(input string nm, input logic [2:0] f, input logic [7:0] bv,
                         input logic [7:0] cv, input logic [7:0] er, input logic ec,
                         input int el);
        int waited = 0;
        logic busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; func = f; b = bv; c = cv;
        @(posedge clk); #1;
        start = 1'b0; func = 3'($urandom); b = 8'($urandom); c = 8'($urandom);
        while (!done && waited < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            waited++;
        end
        chk({nm, " latency"}, waited, el);
        chk({nm, " busy_rot"}, busy_ok, 1'b1);
        chk({nm, " busy_done"}, busy, 1'b1);
        chk({nm, " result"}, result, er);
        chk({nm, " carry"}, carry, ec);
        chk({nm, " zero"}, zero, (er == 8'h00));
        chk({nm, " sign"}, sign, er[7]);
        @(posedge clk); #1;
        chk({nm, " done_pulse"}, {busy, done}, 2'b00);
        chk({nm, " hold"}, result, er);
    endtask

    initial begin
        logic [7:0] er;
        logic       ec;
        int         el;
        logic       saw_done;
        logic [2:0] rf;
        logic [7:0] rb, rc;

        tbl[0]  = '{3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 0};
        tbl[1]  = '{3'd1, 8'hFF, 8'h00, 8'h00, 1'b1, 0};
        tbl[2]  = '{3'd2, 8'hC3, 8'h5A, 8'h42, 1'b0, 0};
        tbl[3]  = '{3'd3, 8'hC3, 8'h5A, 8'hDB, 1'b0, 0};
        tbl[4]  = '{3'd4, 8'hC3, 8'h5A, 8'h99, 1'b0, 0};
        tbl[5]  = '{3'd5, 8'hC3, 8'h5A, 8'h3C, 1'b0, 0};
        tbl[6]  = '{3'd6, 8'h81, 8'h03, 8'h0C, 1'b0, 3};
        tbl[7]  = '{3'd6, 8'h81, 8'h00, 8'h81, 1'b0, 0};
        tbl[8]  = '{3'd6, 8'h81, 8'h07, 8'hC0, 1'b0, 7};
        tbl[9]  = '{3'd6, 8'h81, 8'h0B, 8'h0C, 1'b0, 3};
        tbl[10] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 0};
        tbl[11] = '{3'd1, 8'h7F, 8'h00, 8'h80, 1'b0, 0};
        tbl[12] = '{3'd6, 8'h80, 8'h01, 8'h01, 1'b1, 1};
`ifdef SEQ_ALU_SUB_EN
        tbl[13] = '{3'd7, 8'h05, 8'h07, 8'hFE, 1'b0, 0};
`else
        tbl[13] = '{3'd7, 8'h05, 8'h07, 8'h00, 1'b0, 0};
`endif

        // Reset state
        #12;
        chk("reset outputs", {busy, done, carry, zero, sign, result}, 13'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].f, tbl[i].bv, tbl[i].cv, tbl[i].r, tbl[i].cy,
                  tbl[i].lat);
        end

        // Handshake: start held, func/operands changed during ROT, next op one cycle after done
        @(negedge clk);
        start = 1'b1; func = 3'd6; b = 8'h81; c = 8'h03;
        @(posedge clk); #1;
        func = 3'd0; b = 8'h01; c = 8'h02;
        el = 0;
        while (!done && el < 40) begin @(posedge clk); #1; el++; end
        chk("hs latency", el, 3);
        chk("hs rol result", result, 8'h0C);
        @(posedge clk); #1;
        chk("hs idle gap", {busy, done}, 2'b00);
        @(posedge clk); #1;
        chk("hs next accept", {busy, done}, 2'b11);
        chk("hs next result", result, 8'h03);
        start = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a 7-step rotate
        apply("pre_reset", 3'd3, 8'hC3, 8'h5A, 8'hDB, 1'b0, 0);
        @(negedge clk);
        start = 1'b1; func = 3'd6; b = 8'h81; c = 8'h07;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_rot busy", {busy, done}, 2'b10);
        chk("mid_rot held", result, 8'hDB);
        #2 reset = 1'b1;
        #1;
        chk("async reset", {busy, done, carry, zero, sign, result}, 13'h0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("post reset idle", saw_done, 1'b0);
        chk("post reset result", result, 8'h00);

        // WIDTH=16 ADD wrap
        @(negedge clk);
        start16 = 1'b1; func16 = 3'd0; b16 = 16'hFFFF; c16 = 16'h0001;
        @(posedge clk); #1;
        start16 = 1'b0;
        chk("w16 add", {done16, carry16, zero16, sign16, result16}, {4'b1110, 16'h0000});

        // Random ops against the model
        for (int i = 0; i < 150; i++) begin
            rf = 3'($urandom);
            rb = 8'($urandom);
            rc = 8'($urandom);
            model(rf, rb, rc, er, ec, el);
            apply($sformatf("rnd%0d f%0d", i, rf), rf, rb, rc, er, ec, el);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, clocked successor to the 8-bit combinational ALU in the relay-computer datapath.
- Takes operands B and C plus a 3-bit function code.
- Executes ADD, INC, AND, OR, XOR, NOT, multi-step rotate-left and CLR/SUB.
- Returns a registered result with carry/zero/sign flags through a start/busy/done handshake.
- Rotate steps one bit per clock, mimicking the relay machine's stepping sequencer.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHAMT_W, $clog2(WIDTH), rotate-count width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- func  input  3  000 ADD, 001 INC, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 ROL, 111 CLR (SUB with macro)
- b  input  WIDTH  operand B
- c  input  WIDTH  operand C; ROL count = c[SHAMT_W-1:0]
- busy  output  1  high from accept edge until done cycle, inclusive of rotate steps
- done  output  1  one-cycle pulse, result/flags valid
- result  output  WIDTH  registered result; held until next completion
- carry  output  1  registered carry flag
- zero  output  1  registered: result == 0
- sign  output  1  registered: result[WIDTH-1]

Behaviour:
- Reset (async assert, any state): state=IDLE; result=0, carry=0, zero=0, sign=0, busy=0, done=0; any in-flight rotate is abandoned.
- States: IDLE, ROT, DONE.
- IDLE:
  - start=1 at edge k: func, b, c are captured; later input changes are ignored.
  - Non-ROL ops: result and flags computed and registered at edge k; state -> DONE; done=1 and busy=1 during cycle k+1.
  - ROL with count n=0: result=b, carry=0; -> DONE.
  - ROL with n>0: shift register loads b, counter loads n; -> ROT.
- ROT:
  - Each edge: shift register rotates left by 1 (MSB -> LSB); counter decrements.
  - carry captures the MSB rotated out on that step.
  - When counter reaches 0 at an edge, result is written and state -> DONE.
  - Total: done asserted in cycle k+n+1.
- DONE: one cycle only; done=1, busy=1; -> IDLE. start during DONE or ROT is ignored, not queued.
- Arithmetic (modulo 2^WIDTH):
  - ADD: b+c; carry = bit WIDTH of the sum.
  - INC: b+1; carry set on 2^WIDTH-1 -> 0.
  - AND/OR/XOR/NOT(b): carry=0.
  - CLR: result=0, carry=0, zero=1.
- zero and sign always derive from the value written to result, in the same edge.
- Flags and result change only on completion or reset; stable between operations.
- Back-to-back: start may be held high; next op accepted in the IDLE cycle after DONE, so minimum issue interval is 2 cycles.

Optional Feature:
- Macro SEQ_ALU_SUB_EN.
- Defined: func 111 = SUB, result = b + ~c + 1; carry = 1 when no borrow (b >= c unsigned).
- Undefined: func 111 = CLR as above.
- Port list is identical in both builds.

Test Plan:
- Reset mid-rotate: WIDTH=8, ROL b=8'h81 c=7; assert reset in step 3 -> all outputs 0 immediately (async), IDLE after release, no done pulse.
- ADD overflow: b=8'hF0 c=8'h20 -> one cycle later done=1, result=8'h10, carry=1, zero=0, sign=0; INC b=8'hFF -> result=8'h00, carry=1, zero=1.
- ROL timing: b=8'h81 c=3 accepted at edge k -> busy through k+3, done only in cycle k+4, result=8'h0C, carry=0 (last bit out was 0); c=0 -> done at k+1, result=8'h81.
- Logic ops: b=8'hC3 c=8'h5A -> AND 8'h42, OR 8'hDB, XOR 8'h99, NOT 8'h3C (sign=0), carry=0 each.
- Handshake: start held high, func changed during ROT -> ignored; operands changed after accept do not affect result; next op accepted exactly one cycle after done.
- func 111 with b=8'h05 c=8'h07: macro undefined -> result=0, zero=1; SEQ_ALU_SUB_EN defined -> result=8'hFE, carry=0, sign=1; WIDTH=16 run of ADD 16'hFFFF+1 -> 0, carry=1.
